// File: rtl/sync_pkg.sv
// Shared types and constants for the plateau detector.
package sync_pkg;

    // Detector phases: hunting for a plateau, confirming it, inside a packet,
    // and the dead time that follows a packet.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ARMED   = 2'd1,
        PACKET  = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    // Threshold is a fraction of energy expressed in sixteenths.
    localparam int THR_WIDTH = 4;

    // True whenever the detector is doing anything other than searching.
    function automatic logic is_busy(input state_e s);
        return s != SEARCH;
    endfunction

endpackage

// File: rtl/plateau_detector_if.sv
// Sample stream bundle for the plateau detector.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A source holds valid and its payload stable until the beat
// transfers; ready may change freely and never depends on valid combinationally
// in the sink of this block.
interface plateau_detector_if #(
    parameter int WIDTH = 16
);
    localparam int DW = 2 * WIDTH;

    // Input side: sample {Q,I} plus its aligned signed metrics.
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] s_magnitude;
    logic [DW-1:0] s_energy;
    logic [DW-1:0] s_frequency;

    // Output side: sample, latched frequency estimate and packet flags.
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_user;
    logic          m_first;
    logic          m_last;

    // Sample producer / output consumer.
    modport master (
        output s_valid, s_data, s_magnitude, s_energy, s_frequency, m_ready,
        input  s_ready, m_valid, m_data, m_user, m_first, m_last
    );

    // The detector itself.
    modport slave (
        input  s_valid, s_data, s_magnitude, s_energy, s_frequency, m_ready,
        output s_ready, m_valid, m_data, m_user, m_first, m_last
    );

endinterface

// File: rtl/run_length_counter.sv
// Saturating run-length counter. clr and inc together restart the run at 1,
// so the sample that starts a run is counted by the same enable.
module run_length_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    // Count only on enabled cycles; hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= inc ? WIDTH'(1) : '0;
            end else if (inc && count != MAX_COUNT) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/plateau_detector.sv
// Packet detector: finds runs of samples whose magnitude exceeds a fraction of
// their energy, frames them with first/last flags and latches a frequency
// estimate at packet start. One register stage between input and output.
module plateau_detector #(
    parameter int WIDTH      = 16,
    parameter int PLATEAU    = 16,
    parameter int MAX_LEN    = 4096,
    parameter int HOLDOFF    = 32,
    parameter int GATE       = 1,
    parameter int FREQ_SHIFT = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [sync_pkg::THR_WIDTH-1:0]   cfg_threshold,
    plateau_detector_if.slave                bus,
    output logic                             busy,
    output sync_pkg::state_e                 dbg_state
);

    import sync_pkg::*;

    localparam int DW = 2 * WIDTH;
    localparam int PW = DW + THR_WIDTH + 1;
    localparam int CW = $clog2(PLATEAU) + 1;
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int HW = $clog2(HOLDOFF + 1) + 1;

    localparam logic [CW-1:0] PLAT_LAST   = CW'(PLATEAU - 1);
    localparam logic [LW-1:0] LEN_LAST    = LW'(MAX_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam bit            GATED       = (GATE != 0);
    localparam bit            HAS_HOLDOFF = (HOLDOFF != 0);

    state_e                 state;
    state_e                 next_state;
    logic [LW-1:0]          len;
    logic [THR_WIDTH-1:0]   thr_q;
    logic [THR_WIDTH-1:0]   thr_eff;

    logic                   accept;
    logic                   trigger;
    logic signed [PW-1:0]   energy_ext;
    logic signed [PW-1:0]   mag_ext;
    logic signed [PW-1:0]   thr_ext;
    logic signed [PW-1:0]   product;
    logic signed [PW-1:0]   scaled;
    logic signed [DW-1:0]   freq_scaled;

    logic [CW-1:0]          cnt;
    logic [CW-1:0]          low;
    logic [HW-1:0]          hcnt;
    logic                   cnt_clr, cnt_inc;
    logic                   low_clr, low_inc;
    logic                   hold_clr, hold_inc;
    logic                   start_pkt;
    logic                   end_pkt;
    logic                   in_pkt;

    // Single register stage: take a new sample whenever the output slot is
    // empty or being drained this cycle.
    assign bus.s_ready = !bus.m_valid || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;
    assign busy        = is_busy(state);
    assign dbg_state   = state;

    // Trigger test at full precision; while searching the live threshold is
    // used, since that is the value being latched for the rest of the packet.
    always_comb begin
        thr_eff     = (state == SEARCH) ? cfg_threshold : thr_q;
        energy_ext  = PW'($signed(bus.s_energy));
        mag_ext     = PW'($signed(bus.s_magnitude));
        thr_ext     = $signed(PW'(thr_eff));
        product     = energy_ext * thr_ext;
        scaled      = product >>> THR_WIDTH;
        trigger     = mag_ext > scaled;
        freq_scaled = $signed(bus.s_frequency) >>> FREQ_SHIFT;
    end

    // Next-state and counter control for the sample currently offered.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        low_clr    = 1'b0;
        low_inc    = 1'b0;
        hold_clr   = 1'b0;
        hold_inc   = 1'b0;
        start_pkt  = 1'b0;
        end_pkt    = 1'b0;
        in_pkt     = 1'b0;
        case (state)
            SEARCH: begin
                if (trigger) begin
                    cnt_clr    = 1'b1;
                    cnt_inc    = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (trigger) begin
                    if (cnt == PLAT_LAST) begin
                        start_pkt  = 1'b1;
                        in_pkt     = 1'b1;
                        cnt_clr    = 1'b1;
                        low_clr    = 1'b1;
                        next_state = PACKET;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    cnt_clr    = 1'b1;
                    next_state = SEARCH;
                end
            end
            PACKET: begin
                in_pkt = 1'b1;
                // Length and low-run endings share one exit so a coincidence
                // still yields a single last flag.
                if ((!trigger && low == PLAT_LAST) || len == LEN_LAST) begin
                    end_pkt    = 1'b1;
                    low_clr    = 1'b1;
                    hold_clr   = 1'b1;
                    next_state = HAS_HOLDOFF ? sync_pkg::HOLDOFF : SEARCH;
                end else if (trigger) begin
                    low_clr = 1'b1;
                end else begin
                    low_inc = 1'b1;
                end
            end
            sync_pkg::HOLDOFF: begin
                if (hcnt == HOLD_LAST) begin
                    hold_clr   = 1'b1;
                    next_state = SEARCH;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: begin
                next_state = SEARCH;
            end
        endcase
    end

    // Consecutive-trigger count while arming.
    run_length_counter #(.WIDTH(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    // Consecutive non-trigger count inside a packet.
    run_length_counter #(.WIDTH(CW)) u_low (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (low_clr),
        .inc   (low_inc),
        .count (low)
    );

    // Samples consumed since the packet ended.
    run_length_counter #(.WIDTH(HW)) u_hold (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .count (hcnt)
    );

    // State, packet length, latched threshold and the output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            len         <= '0;
            thr_q       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_user  <= '0;
            bus.m_first <= 1'b0;
            bus.m_last  <= 1'b0;
        end else if (accept) begin
            state <= next_state;
            if (state == SEARCH) begin
                thr_q <= cfg_threshold;
            end
            if (start_pkt) begin
                len <= LW'(1);
            end else if (end_pkt) begin
                len <= '0;
            end else if (state == PACKET) begin
                len <= len + 1'b1;
            end
            bus.m_valid <= GATED ? in_pkt : 1'b1;
            bus.m_data  <= bus.s_data;
            bus.m_first <= start_pkt;
            bus.m_last  <= end_pkt;
            if (start_pkt) begin
                bus.m_user <= freq_scaled;
            end
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end

endmodule
